posit_decode_pipe: RTL and testbench
====================================

// Module: posit_decode_pipe
// PURPOSE
//  Pipelined, flow-controlled posit<WIDTH,ES> field decoder (next generation of the comb format decoder).
//  Adds: valid/ready handshake with full backpressure, a runtime-independent ES parameter following
//  standard posit exponent semantics, combined scale output, zero/NaR flags and a tag sideband.
//  Sits between the operand register file and the posit arithmetic core; 3 register stages, 1 result/cycle.
// PARAMETERS
//  WIDTH   16                  posit word width, >= 5
//  ES      1                   exponent field size, 0..WIDTH-3
//  TAG_W   4                   opaque sideband width carried alongside each operand, >= 1
//  W_REG   $clog2(WIDTH)+1     signed regime width
//  W_SCALE W_REG+ES            signed scale width
//  W_MAN   WIDTH               mantissa width, hidden bit at MSB
// PORTS
//  clk       in   1        clock, all state on rising edge
//  rst_n     in   1        asynchronous active-low reset
//  in_valid  in   1        input operand valid
//  in_ready  out  1        decoder can accept operand this cycle
//  in_posit  in   WIDTH    raw posit word
//  in_tag    in   TAG_W    sideband, returned unchanged with result
//  out_valid out  1        result valid
//  out_ready in   1        downstream accepts result this cycle
//  out_sign  out  1        0 = positive, 1 = negative
//  out_regime out W_REG    signed regime k
//  out_exp   out  ES (min 1) unsigned exponent e (tied 0 when ES=0)
//  out_scale out  W_SCALE  signed k*2^ES + e
//  out_man   out  W_MAN    {1'b1, fraction left-aligned, zero fill}
//  out_zero  out  1        input was 0
//  out_nar   out  1        input was NaR (1 followed by zeros)
//  out_tag   out  TAG_W    sideband of this result
// BEHAVIOUR
//  Reset (rst_n low, async): all stage valid bits and all output registers = 0; in_ready = 1 once valid bits clear.
//  Stages: S1 captures sign, |posit| (two's complement if negative), zero/NaR detect, tag.
//          S2 counts regime run on body=|posit|[WIDTH-2:0] (run of copies of body MSB, capped WIDTH-1),
//             computes k (= run-1 if MSB=1, else -run), left-shifts body past regime+terminator.
//          S3 slices exponent (next ES bits; bits beyond the word read as 0, i.e. missing LSBs are zero),
//             fraction (remaining bits), forms scale and mantissa; S3 registers drive outputs directly.
//  Flow control: stage n loads when its valid=0 or stage n+1 loads this cycle; S3 loads when
//   out_valid=0 or out_ready=1. in_ready = S1 load condition (combinational from state and out_ready only,
//   never from in_valid). Bubbles collapse; no data loss or duplication.
//  Transfer on in_valid&in_ready; output transfer on out_valid&out_ready.
//  Latency 3 cycles accept->out_valid with no stall; throughput 1/cycle with out_ready held 1.
//  While out_valid=1 and out_ready=0, every out_* holds stable.
//  Simultaneous accept and output transfer in a full pipe: both occur, occupancy unchanged.
//  Zero / NaR: flag set, sign/regime/exp/scale/man forced 0 (NaR sign also 0).
//  Width rules: scale computed in W_SCALE signed, no overflow for any legal WIDTH/ES; mantissa
//   fraction holds at most WIDTH-3-ES bits, always fits W_MAN.
//  Reset mid-operation: in-flight operands discarded, out_valid drops asynchronously.
//  in_posit/in_tag ignored when in_valid=0; X on them must not propagate to valid bits.
// TESTING  (WIDTH=8, ES=1)
//  0x40 -> sign0 k=0 e=0 scale=0 man=0x80; 0x50 -> k=0 e=1 scale=1; 0x48 -> scale=0 man=0xC0 (1.5).
//  0x7F -> k=6 scale=12 e=0; 0x01 -> k=-6 scale=-12; 0xC0 -> sign1 scale=0 man=0x80.
//  0x00 -> out_zero=1 others 0; 0x80 -> out_nar=1 others 0.
//  Stream 10 words, out_ready=1 -> results 3 cycles later, back-to-back, in order, tags 0..9 preserved.
//  Hold out_ready=0 for 6 cycles while streaming -> in_ready falls after 3 accepts, outputs stable,
//   release -> all words delivered once, in order.
//  Assert rst_n low with 3 operands in flight -> out_valid=0 immediately; after release, no stale result appears.

Source files
------------

// File: rtl/posit_decode_if.sv
// posit_decode_if: operand-in / decoded-result-out handshake bundle for the posit decoder.
interface posit_decode_if #(
  parameter int WIDTH = 16,
  parameter int ES    = 1,
  parameter int TAG_W = 4
);
  localparam int W_REG   = $clog2(WIDTH) + 1;
  localparam int W_SCALE = W_REG + ES;
  localparam int W_MAN   = WIDTH;
  localparam int W_EXP   = (ES > 0) ? ES : 1;
  logic                      in_valid;
  logic                      in_ready;
  logic [WIDTH-1:0]          in_posit;
  logic [TAG_W-1:0]          in_tag;
  logic                      out_valid;
  logic                      out_ready;
  logic                      out_sign;
  logic signed [W_REG-1:0]   out_regime;
  logic [W_EXP-1:0]          out_exp;
  logic signed [W_SCALE-1:0] out_scale;
  logic [W_MAN-1:0]          out_man;
  logic                      out_zero;
  logic                      out_nar;
  logic [TAG_W-1:0]          out_tag;
  modport master (
    output in_valid, in_posit, in_tag, out_ready,
    input  in_ready, out_valid, out_sign, out_regime, out_exp, out_scale, out_man,
           out_zero, out_nar, out_tag
  );
  modport slave (
    input  in_valid, in_posit, in_tag, out_ready,
    output in_ready, out_valid, out_sign, out_regime, out_exp, out_scale, out_man,
           out_zero, out_nar, out_tag
  );
endinterface

// File: rtl/posit_decode_pipe.sv
// posit_decode_pipe: 3-stage valid/ready posit<WIDTH,ES> field decoder with zero/NaR flags and tag sideband.
module posit_decode_pipe #(
  parameter int WIDTH = 16,
  parameter int ES    = 1,
  parameter int TAG_W = 4
) (
  input logic          clk,
  input logic          rst_n,
  posit_decode_if.slave bus
);
  localparam int W_REG   = $clog2(WIDTH) + 1;
  localparam int W_SCALE = W_REG + ES;
  localparam int W_EXP   = (ES > 0) ? ES : 1;
  logic w_ld1, w_ld2, w_ld3;
  logic r1_v, r2_v, r3_v;
  assign w_ld3        = !r3_v || bus.out_ready;
  assign w_ld2        = !r2_v || w_ld3;
  assign w_ld1        = !r1_v || w_ld2;
  assign bus.in_ready = w_ld1;
  logic               r1_sign, r1_zero, r1_nar;
  logic [WIDTH-2:0]   r1_body;
  logic [TAG_W-1:0]   r1_tag;
  logic               w_zero, w_nar;
  assign w_zero = bus.in_posit == '0;
  assign w_nar  = bus.in_posit == {1'b1, {(WIDTH-1){1'b0}}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r1_v    <= 1'b0;
      r1_sign <= 1'b0;
      r1_zero <= 1'b0;
      r1_nar  <= 1'b0;
      r1_body <= '0;
      r1_tag  <= '0;
    end else if (w_ld1) begin
      r1_v <= bus.in_valid;
      if (bus.in_valid) begin
        r1_sign <= bus.in_posit[WIDTH-1];
        r1_zero <= w_zero;
        r1_nar  <= w_nar;
        r1_body <= (WIDTH-1)'(bus.in_posit[WIDTH-1] ? -bus.in_posit : bus.in_posit);
        r1_tag  <= bus.in_tag;
      end
    end
  logic [W_REG-1:0]        w_run;
  logic                    w_stop;
  logic signed [W_REG-1:0] w_k;
  logic [WIDTH-2:0]        w_rem;
  // run of copies of the body MSB; all-same body saturates at WIDTH-1
  always_comb begin
    w_run  = '0;
    w_stop = 1'b0;
    for (int i = WIDTH-2; i >= 0; i--) begin
      w_stop = w_stop || (r1_body[i] != r1_body[WIDTH-2]);
      w_run  = w_run + W_REG'(!w_stop);
    end
  end
  assign w_k   = r1_body[WIDTH-2] ? w_run - 1'b1 : -w_run;
  assign w_rem = r1_body << (w_run + 1'b1);
  logic                    r2_sign, r2_zero, r2_nar;
  logic signed [W_REG-1:0] r2_k;
  logic [WIDTH-2:0]        r2_rem;
  logic [TAG_W-1:0]        r2_tag;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r2_v    <= 1'b0;
      r2_sign <= 1'b0;
      r2_zero <= 1'b0;
      r2_nar  <= 1'b0;
      r2_k    <= '0;
      r2_rem  <= '0;
      r2_tag  <= '0;
    end else if (w_ld2) begin
      r2_v <= r1_v;
      if (r1_v) begin
        r2_sign <= r1_sign;
        r2_zero <= r1_zero;
        r2_nar  <= r1_nar;
        r2_k    <= w_k;
        r2_rem  <= w_rem;
        r2_tag  <= r1_tag;
      end
    end
  logic [W_EXP-1:0]          w_exp;
  logic [WIDTH-2:0]          w_frac;
  logic signed [W_SCALE-1:0] w_scale;
  logic                      w_special;
  generate
    if (ES > 0) begin : g_exp
      assign w_exp = r2_rem[WIDTH-2 -: ES];
    end else begin : g_noexp
      assign w_exp = '0;
    end
  endgenerate
  assign w_frac    = r2_rem << ES;
  assign w_scale   = (W_SCALE'(r2_k) <<< ES) + W_SCALE'(w_exp);
  assign w_special = r2_zero || r2_nar;
  logic                      r3_sign, r3_zero, r3_nar;
  logic signed [W_REG-1:0]   r3_k;
  logic [W_EXP-1:0]          r3_exp;
  logic signed [W_SCALE-1:0] r3_scale;
  logic [WIDTH-1:0]          r3_man;
  logic [TAG_W-1:0]          r3_tag;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r3_v     <= 1'b0;
      r3_sign  <= 1'b0;
      r3_zero  <= 1'b0;
      r3_nar   <= 1'b0;
      r3_k     <= '0;
      r3_exp   <= '0;
      r3_scale <= '0;
      r3_man   <= '0;
      r3_tag   <= '0;
    end else if (w_ld3) begin
      r3_v <= r2_v;
      if (r2_v) begin
        r3_sign  <= w_special ? 1'b0 : r2_sign;
        r3_zero  <= r2_zero;
        r3_nar   <= r2_nar;
        r3_k     <= w_special ? '0 : r2_k;
        r3_exp   <= w_special ? '0 : w_exp;
        r3_scale <= w_special ? '0 : w_scale;
        r3_man   <= w_special ? '0 : {1'b1, w_frac};
        r3_tag   <= r2_tag;
      end
    end
  assign bus.out_valid  = r3_v;
  assign bus.out_sign   = r3_sign;
  assign bus.out_regime = r3_k;
  assign bus.out_exp    = r3_exp;
  assign bus.out_scale  = r3_scale;
  assign bus.out_man    = r3_man;
  assign bus.out_zero   = r3_zero;
  assign bus.out_nar    = r3_nar;
  assign bus.out_tag    = r3_tag;
endmodule

// File: tb/tb_posit_decode_pipe.sv
// tb_posit_decode_pipe: scoreboard bench for posit_decode_pipe at WIDTH=8, ES=1 with directed vectors.
module tb_posit_decode_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  posit_decode_if #(.WIDTH(8), .ES(1), .TAG_W(4)) b();
  posit_decode_pipe #(.WIDTH(8), .ES(1), .TAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
  typedef struct { logic [24:0] v; int acc; bit lat; } sb_t;
  sb_t q[$];
  int total = 0, bad = 0, cyc = 0, n_acc = 0, n_out = 0, last_acc = 0;
  bit lat_on = 1'b1;
  localparam int NV = 12;
  // expected layout: {sign, k[3:0], e, scale[4:0], man[7:0], zero, nar}
  logic [7:0]  vp [NV] = '{8'h40, 8'h50, 8'h48, 8'h7F, 8'h01, 8'hC0,
                           8'h00, 8'h80, 8'h30, 8'h6C, 8'hB0, 8'hE4};
  logic [20:0] ve [NV] = '{
    {1'b0, 4'd0,    1'b0, 5'd0,     8'h80, 2'b00},
    {1'b0, 4'd0,    1'b1, 5'd1,     8'h80, 2'b00},
    {1'b0, 4'd0,    1'b0, 5'd0,     8'hC0, 2'b00},
    {1'b0, 4'd6,    1'b0, 5'd12,    8'h80, 2'b00},
    {1'b0, 4'b1010, 1'b0, 5'b10100, 8'h80, 2'b00},
    {1'b1, 4'd0,    1'b0, 5'd0,     8'h80, 2'b00},
    {1'b0, 4'd0,    1'b0, 5'd0,     8'h00, 2'b10},
    {1'b0, 4'd0,    1'b0, 5'd0,     8'h00, 2'b01},
    {1'b0, 4'b1111, 1'b1, 5'b11111, 8'h80, 2'b00},
    {1'b0, 4'd1,    1'b1, 5'd3,     8'hC0, 2'b00},
    {1'b1, 4'd0,    1'b1, 5'd1,     8'h80, 2'b00},
    {1'b1, 4'b1110, 1'b1, 5'b11101, 8'hC0, 2'b00}};
  logic [24:0] cur;
  assign cur = {b.out_sign, b.out_regime, b.out_exp, b.out_scale, b.out_man,
                b.out_zero, b.out_nar, b.out_tag};
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] r);
    total++;
    if (a !== r) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, a, r);
    end
  endtask
  task automatic send(input logic [7:0] p, input logic [3:0] t, input logic [20:0] e);
    bit ok = 1'b0;
    @(posedge clk); #1;
    b.in_valid = 1'b1;
    b.in_posit = p;
    b.in_tag   = t;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (b.in_ready) begin
        q.push_back('{v: {e, t}, acc: cyc, lat: lat_on});
        n_acc++;
        last_acc = cyc;
        ok = 1'b1;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask
  task automatic idle();
    @(posedge clk); #1;
    b.in_valid = 1'b0;
    b.in_posit = 'x;
    b.in_tag   = 'x;
  endtask
  task automatic drain();
    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask
  initial begin : monitor
    logic [24:0] snap;
    bit held = 1'b0;
    sb_t s;
    forever begin
      @(negedge clk);
      if (!rst_n) held = 1'b0;
      else begin
        if (b.out_valid && !b.out_ready) begin
          if (held) chk("hold_stable", cur, snap);
          snap = cur;
          held = 1'b1;
        end else held = 1'b0;
        if (b.out_valid && b.out_ready) begin
          if (q.size() == 0) chk("spurious_out", 1, 0);
          else begin
            s = q.pop_front();
            n_out++;
            chk("result", cur, s.v);
            if (s.lat) chk("latency", cyc - s.acc, 3);
          end
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int a0, first, n_before;
    b.in_valid  = 1'b0;
    b.in_posit  = 'x;
    b.in_tag    = 'x;
    b.out_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("rst_out_valid", b.out_valid, 0);
    chk("rst_in_ready", b.in_ready, 1);
    chk("rst_outputs", cur, 0);
    rst_n = 1'b1;
    b.out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      send(vp[i], 4'(i + 3), ve[i]);
      idle();
    end
    drain();
    for (int i = 0; i < 10; i++) begin
      send(vp[i], 4'(i), ve[i]);
      if (i == 0) first = last_acc;
    end
    idle();
    chk("b2b_accepts", last_acc - first, 9);
    drain();
    lat_on = 1'b0;
    @(posedge clk); #1;
    b.out_ready = 1'b0;
    a0 = n_acc;
    fork
      begin
        for (int i = 0; i < 6; i++) send(vp[i + 2], 4'(i + 8), ve[i + 2]);
        idle();
      end
      begin
        repeat (6) @(negedge clk);
        chk("bp_accepts", n_acc - a0, 3);
        chk("bp_in_ready", b.in_ready, 0);
        @(posedge clk); #1;
        b.out_ready = 1'b1;
      end
    join
    drain();
    chk("delivered_once", n_out, n_acc);
    @(posedge clk); #1;
    b.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(vp[i + 9], 4'(i + 1), ve[i + 9]);
    idle();
    chk("inflight_valid", b.out_valid, 1);
    n_before = n_out;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_valid", b.out_valid, 0);
    chk("rst_async_ready", b.in_ready, 1);
    q.delete();
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    b.out_ready = 1'b1;
    repeat (10) @(posedge clk);
    chk("no_stale", n_out, n_before);
    chk("queue_empty", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
